// File: rtl/feature_vector_sequencer_if.sv
// Handshake bundle for the feature sequencer:
// serial feature beats in, classifier results out.
interface feature_vector_sequencer_if #(
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 2,
  parameter int IDX_W    = 16
) ();
  logic                s_valid;
  logic                s_ready;
  logic [WIDTH_A-1:0]  s_data;
  logic                s_last;
  logic                m_valid;
  logic                m_ready;
  logic [OUTWIDTH-1:0] m_class;
  logic [IDX_W-1:0]    m_index;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class, m_index
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_index
  );
endinterface

// File: rtl/feature_vector_sequencer.sv
// Serial feature assembler, settle timer and
// result capture in front of a slow printed classifier.
module feature_vector_sequencer #(
  parameter int WIDTH_A       = 4,
  parameter int NUM_A         = 21,
  parameter int OUTWIDTH      = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int IDX_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  feature_vector_sequencer_if.slave  bus,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        cls_out,
  output logic                       err_len
);

  localparam int IW = $clog2(NUM_A + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_A - 1);
  localparam logic [CW-1:0] CEND = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    OUT
  } state_t;

  state_t                     state, state_d;
  logic [IW-1:0]              idx, idx_d;
  logic [CW-1:0]              cnt, cnt_d;
  logic [NUM_A*WIDTH_A-1:0]   inp_d;
  logic                       err_d;
  logic                       mv, mv_d;
  logic [OUTWIDTH-1:0]        mc, mc_d;
  logic [IDX_W-1:0]           mi, mi_d;

  assign bus.s_ready = (state == LOAD);
  assign bus.m_valid = mv;
  assign bus.m_class = mc;
  assign bus.m_index = mi;

  // Next-state: slot fill, framing check, settle timer, result handshake.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    inp_d   = inp;
    err_d   = 1'b0;
    mv_d    = mv;
    mc_d    = mc;
    mi_d    = mi;
    unique case (state)
      LOAD: begin
        if (bus.s_valid) begin
          for (int k = 0; k < NUM_A; k++) begin
            if (idx == IW'(k)) begin
              inp_d[k*WIDTH_A +: WIDTH_A] = bus.s_data;
            end
          end
          if (idx == LAST) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = SETTLE;
            err_d   = !bus.s_last;
          end else if (bus.s_last) begin
            idx_d = '0;
            err_d = 1'b1;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      SETTLE: begin
        if (cnt == CEND) begin
          mc_d    = cls_out;
          mv_d    = 1'b1;
          state_d = OUT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      OUT: begin
        if (bus.m_ready) begin
          mv_d    = 1'b0;
          mi_d    = mi + IDX_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      idx     <= '0;
      cnt     <= '0;
      inp     <= '0;
      err_len <= 1'b0;
      mv      <= 1'b0;
      mc      <= '0;
      mi      <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      inp     <= inp_d;
      err_len <= err_d;
      mv      <= mv_d;
      mc      <= mc_d;
      mi      <= mi_d;
    end
  end

endmodule

// File: tb/tb_feature_vector_sequencer.sv
// Scoreboard bench for feature_vector_sequencer:
// two instances (16-bit and 2-bit index) driven in lockstep.
module tb_feature_vector_sequencer;

  localparam int W = 4;
  localparam int N = 21;
  localparam int O = 2;
  localparam int S = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  feature_vector_sequencer_if #(.WIDTH_A(W), .OUTWIDTH(O), .IDX_W(16)) fa ();
  feature_vector_sequencer_if #(.WIDTH_A(W), .OUTWIDTH(O), .IDX_W(2))  fb ();

  logic [N*W-1:0] inp_a, inp_b;
  logic [O-1:0]   cls_a, cls_b;
  logic           err_a, err_b;
  logic [O-1:0]   flip = '0;

  function automatic logic [1:0] model(input logic [N*W-1:0] v);
    logic [7:0] s;
    s = 8'd3;
    for (int k = 0; k < N; k++) s = s + 8'(v[k*W +: W]);
    return s[1:0];
  endfunction

  assign cls_a = model(inp_a) ^ flip;
  assign cls_b = model(inp_b) ^ flip;

  feature_vector_sequencer #(
    .WIDTH_A(W), .NUM_A(N), .OUTWIDTH(O),
    .SETTLE_CYCLES(S), .IDX_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(fa),
    .inp(inp_a), .cls_out(cls_a), .err_len(err_a)
  );

  feature_vector_sequencer #(
    .WIDTH_A(W), .NUM_A(N), .OUTWIDTH(O),
    .SETTLE_CYCLES(S), .IDX_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(fb),
    .inp(inp_b), .cls_out(cls_b), .err_len(err_b)
  );

  typedef struct {
    logic [1:0] c;
    int         i;
  } exp_t;

  exp_t           q[$];
  int             total = 0;
  int             bad = 0;
  int             nidx = 0;
  logic [N*W-1:0] shadow = '0;
  logic [1:0]     last_cls = '0;
  int             last_gap = 0;

  task automatic drive_in(input logic v, input logic [3:0] d, input logic l);
    fa.s_valid = v; fb.s_valid = v;
    fa.s_data  = d; fb.s_data  = d;
    fa.s_last  = l; fb.s_last  = l;
  endtask

  task automatic set_ready(input logic r);
    fa.m_ready = r; fb.m_ready = r;
  endtask

  task automatic do_reset();
    drive_in(1'b0, 4'h0, 1'b0);
    set_ready(1'b0);
    flip = '0;
    #3 rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    shadow = '0;
    nidx = 0;
    q.delete();
  endtask

  task automatic beat(input logic [3:0] d, input logic l);
    int n;
    @(negedge clk);
    drive_in(1'b1, d, l);
    n = 0;
    while (!fa.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!fa.s_ready) begin
      total++; bad++;
      $display("FAIL beat_wait s_ready=%0b want 1", fa.s_ready);
    end
    @(posedge clk);
  endtask

  task automatic run_vec(input int first, input int short_at,
                         input bit nolast, input int hold);
    int nb, k, gap;
    bit errseen, stable, experr;
    logic l;
    logic [3:0] d;
    logic [1:0] c0;
    logic [15:0] i0;
    exp_t e;
    nb = (short_at > 0) ? short_at : N;
    experr = (short_at > 0) || nolast;
    for (int b = 0; b < nb; b++) begin
      if (short_at > 0) l = (b == nb - 1);
      else l = !nolast && (b == N - 1);
      d = 4'((first + b) % 16);
      beat(d, l);
      shadow[b*W +: W] = d;
    end
    @(negedge clk);
    total++;
    if (err_a !== experr || err_b !== experr) begin
      bad++;
      $display("FAIL err_len got=%0b/%0b want=%0b", err_a, err_b, experr);
    end
    if (short_at > 0) begin
      drive_in(1'b0, 4'h0, 1'b0);
      total++;
      if (fa.m_valid !== 1'b0 || fa.s_ready !== 1'b1) begin
        bad++;
        $display("FAIL short_state m_valid=%0b s_ready=%0b want 0/1",
                 fa.m_valid, fa.s_ready);
      end
      @(negedge clk);
      total++;
      if (err_a !== 1'b0 || fa.m_valid !== 1'b0) begin
        bad++;
        $display("FAIL err_pulse err=%0b m_valid=%0b want 0/0",
                 err_a, fa.m_valid);
      end
      return;
    end
    total++;
    if (inp_a !== shadow || inp_b !== shadow) begin
      bad++;
      $display("FAIL inp got=%h want=%h", inp_a, shadow);
    end
    e.c = model(shadow);
    e.i = nidx;
    q.push_back(e);
    drive_in(1'b1, 4'hF, 1'b1);
    k = 0; gap = 0; errseen = 0;
    while (!fa.m_valid && k < 100) begin
      if (!fa.s_ready) gap++;
      @(negedge clk);
      k++;
      if (err_a || err_b) errseen = 1;
    end
    total++;
    if (k !== S) begin
      bad++;
      $display("FAIL latency got=%0d want=%0d", k, S);
    end
    total++;
    if (errseen || inp_a !== shadow) begin
      bad++;
      $display("FAIL settle_quiet err=%0b inp=%h want 0/%h",
               errseen, inp_a, shadow);
    end
    if (hold > 0) begin
      c0 = fa.m_class; i0 = fa.m_index; stable = 1;
      for (int h = 0; h < hold; h++) begin
        flip = flip + 2'd1;
        @(negedge clk);
        if (fa.m_class !== c0 || fa.m_index !== i0 ||
            fa.s_ready !== 1'b0 || fa.m_valid !== 1'b1) stable = 0;
      end
      flip = '0;
      total++;
      if (!stable) begin
        bad++;
        $display("FAIL hold_stable class=%0d idx=%0d want %0d/%0d",
                 fa.m_class, fa.m_index, c0, i0);
      end
      set_ready(1'b1);
    end
    if (!fa.s_ready) gap++;
    e = q.pop_front();
    total++;
    if (fa.m_class !== e.c || fa.m_index !== 16'(e.i) ||
        fb.m_class !== e.c || fb.m_index !== 2'(e.i)) begin
      bad++;
      $display("FAIL result class=%0d/%0d idx=%0d/%0d want %0d idx %0d",
               fa.m_class, fb.m_class, fa.m_index, fb.m_index, e.c, e.i);
    end
    last_cls = fa.m_class;
    nidx++;
    @(negedge clk);
    drive_in(1'b0, 4'h0, 1'b0);
    total++;
    if (fa.m_valid !== 1'b0 || fa.s_ready !== 1'b1 ||
        fb.m_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_hs m_valid=%0b s_ready=%0b want 0/1",
               fa.m_valid, fa.s_ready);
    end
    last_gap = gap;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (inp_a !== '0 || inp_b !== '0) begin
      bad++; $display("FAIL rst_inp got=%h want 0", inp_a);
    end
    total++;
    if (fa.m_valid !== 1'b0 || fb.m_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mvalid got=%0b want 0", fa.m_valid);
    end
    total++;
    if (fa.m_class !== '0 || fa.m_index !== '0 || fb.m_index !== '0) begin
      bad++;
      $display("FAIL rst_result class=%0d idx=%0d want 0/0",
               fa.m_class, fa.m_index);
    end
    total++;
    if (err_a !== 1'b0 || fa.s_ready !== 1'b1 || fb.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ctl err=%0b s_ready=%0b want 0/1",
               err_a, fa.s_ready);
    end
  endtask

  task automatic test_basic();
    set_ready(1'b1);
    run_vec(1, 0, 0, 0);
    total++;
    if (last_cls !== 2'd2) begin
      bad++; $display("FAIL basic_class got=%0d want 2", last_cls);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_ready(1'b1);
    for (int v = 0; v < 3; v++) begin
      run_vec(3 + v * 5, 0, 0, 0);
      total++;
      if (last_gap !== S + 1) begin
        bad++;
        $display("FAIL gap got=%0d want=%0d", last_gap, S + 1);
      end
    end
  endtask

  task automatic test_short();
    do_reset();
    set_ready(1'b1);
    run_vec(7, 5, 0, 0);
    run_vec(2, 0, 0, 0);
  endtask

  task automatic test_nolast();
    set_ready(1'b1);
    run_vec(9, 0, 1, 0);
  endtask

  task automatic test_hold();
    set_ready(1'b0);
    run_vec(4, 0, 0, 50);
  endtask

  task automatic test_reset_mid();
    set_ready(1'b1);
    for (int b = 0; b < N; b++) beat(4'(b + 6), b == N - 1);
    drive_in(1'b0, 4'h0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    test_reset();
    set_ready(1'b1);
    for (int v = 0; v < 5; v++) run_vec(11 + v * 3, 0, 0, 0);
  endtask

  initial begin
    drive_in(1'b0, 4'h0, 1'b0);
    set_ready(1'b0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_nolast();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/feature_vector_sequencer.md
Name: feature_vector_sequencer

Overview:
Clocked front-end for the combinational printed classifier `top`. It does four things:
- assembles a serial stream of WIDTH_A-bit features into the flat NUM_A*WIDTH_A input vector;
- holds that vector stable for a programmable settle time, allowing for the slow printed logic;
- captures the classifier decision;
- returns the decision on a valid/ready output with a sample index.

It replaces fixed-period stimulus pacing with a handshaked pipeline stage. The stage runs at any clock rate and flags mis-framed vectors.

Parameters:
- WIDTH_A, 4, bits per feature
- NUM_A, 21, features per vector
- OUTWIDTH, 2, classifier output width
- SETTLE_CYCLES, 16, clock cycles the vector is held before capture; must be >= 1
- IDX_W, 16, width of sample index counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  feature beat valid
- s_ready  out  1  sequencer can accept a feature
- s_data  in  WIDTH_A  feature value
- s_last  in  1  marks final feature of a vector
- inp  out  NUM_A*WIDTH_A  registered vector to classifier; feature k at bits [(k+1)*WIDTH_A-1 : k*WIDTH_A]
- cls_out  in  OUTWIDTH  classifier decision (combinational from inp)
- m_valid  out  1  result valid
- m_ready  in  1  result consumer ready
- m_class  out  OUTWIDTH  captured decision
- m_index  out  IDX_W  index of the sample producing m_class
- err_len  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync release): state=LOAD, slot index idx=0, settle count=0, inp=0, m_valid=0, m_class=0, m_index=0, err_len=0. s_ready=1 in the first cycle after release.
- s_ready is 1 only in state LOAD. Other outputs are registered.
- A beat is accepted on a clock edge where s_valid && s_ready.

State LOAD:
- Accepted beat writes s_data into slot idx of inp.
- If idx < NUM_A-1 and s_last=0: idx increments.
- If idx < NUM_A-1 and s_last=1 (short vector): err_len pulses, idx resets to 0, and the vector is discarded. State stays LOAD. Stale slots are not cleared.
- If idx == NUM_A-1: idx resets to 0 and state goes to SETTLE, with settle count=0.
  - If s_last=0 at that beat (missing last), err_len also pulses, but the vector is still used.
  - Subsequent beats start a new vector.

State SETTLE:
- inp is held stable.
- Settle count increments each cycle.
- On the edge where count == SETTLE_CYCLES-1:
  - m_class <= cls_out and m_valid <= 1;
  - state goes to OUT.
- Latency: m_valid rises exactly SETTLE_CYCLES edges after the edge accepting the final feature.

State OUT:
- m_valid, m_class and m_index are held until m_ready=1.
- On the handshake edge: m_valid <= 0, m_index increments (wraps 2^IDX_W-1 to 0), state goes to LOAD.
- m_index presented with a result equals the number of prior completed handshakes.
- m_ready while m_valid=0 has no effect.
- Back-to-back throughput: one vector per NUM_A + SETTLE_CYCLES + 1 cycles minimum, with m_ready tied high.

Other rules:
- s_valid and s_last outside LOAD are ignored; no beat is consumed.
- Reset asserted mid-vector or mid-SETTLE/OUT aborts everything. There is no partial result and no err_len; the first post-reset beat goes to slot 0.
- err_len never coincides with m_valid rising.

Test Plan:
1. Defaults; stream features 1..21 (mod 16) with s_last on beat 21; classifier model returns 2; m_ready=1.
   - Required: inp holds the expected packed vector.
   - Required: m_valid rises 16 edges after beat 21, with m_class=2, m_index=0, err_len never set.
2. Three vectors back-to-back, m_ready=1.
   - Required: m_index 0,1,2.
   - Required: s_ready low for exactly 17 cycles after each 21st beat.
   - Required: s_valid held high during those cycles consumes nothing.
3. s_last on beat 5.
   - Required: err_len pulses once on that edge.
   - Required: no m_valid; next 21 beats form a vector whose result carries m_index=0.
4. 21 beats with s_last=0 throughout.
   - Required: err_len pulses on beat 21; result is still produced, with m_class matching the model.
5. m_ready held low 50 cycles after m_valid, while cls_out changes.
   - Required: m_class and m_index stay stable; s_ready stays 0.
   - Required: after the handshake, m_valid=0 on the next edge and s_ready=1.
6. Reset pulses mid-SETTLE, then at IDX_W=2 run 5 vectors.
   - Required: after reset, outputs are all 0 with s_ready=1.
   - Required: m_index sequence is 0,1,2,3,0.
